// File: rtl/float_mul_pipe_prod.sv
// float_mul_pipe_prod
//   Second stage of the pipelined single-precision FP multiplier. Takes the
//   unpacked operands from the unpack/exponent stage and forms the exact
//   2*FRAC_W-bit fraction product through two registered stages (A, B).
//   Stage A forms two partial products by splitting the b fraction at SPLIT;
//   stage B recombines them. Side fields travel alongside the product.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   flush               synchronous kill of all in-flight ops
//   in_valid/in_ready   upstream handshake
//   m_*                 unpacked operands and side fields from upstream
//   out_valid/out_ready downstream handshake to the normalize/round stage
//   n_*                 registered side fields and n_frac48 = a * b (exact)
module float_mul_pipe_prod #(
  parameter int EXP_W  = 10,
  parameter int FRAC_W = 24,
  parameter int SPLIT  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  m_sign,
  input  logic [EXP_W-1:0]      m_exp10,
  input  logic                  m_is_inf_nan,
  input  logic [22:0]           m_inf_nan_frac,
  input  logic [FRAC_W-1:0]     m_a_frac24,
  input  logic [FRAC_W-1:0]     m_b_frac24,
  input  logic [1:0]            m_rm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  n_sign,
  output logic [EXP_W-1:0]      n_exp10,
  output logic                  n_is_inf_nan,
  output logic [22:0]           n_inf_nan_frac,
  output logic [1:0]            n_rm,
  output logic [2*FRAC_W-1:0]   n_frac48
);

  localparam int LO_W = FRAC_W + SPLIT;       // a * b[SPLIT-1:0]
  localparam int HI_W = 2*FRAC_W - SPLIT;     // a * b[FRAC_W-1:SPLIT]
  localparam int P_W  = 2*FRAC_W;

  // Stage A state
  logic              a_vld;
  logic              a_sign;
  logic [EXP_W-1:0]  a_exp10;
  logic              a_is_inf_nan;
  logic [22:0]       a_inf_nan_frac;
  logic [1:0]        a_rm;
  logic [LO_W-1:0]   a_p_lo;
  logic [HI_W-1:0]   a_p_hi;

  // Stage B valid (data regs are the n_* outputs)
  logic              b_vld;

  logic              b_adv;
  logic              a_adv;
  logic              accept;
  logic [LO_W-1:0]   p_lo;
  logic [HI_W-1:0]   p_hi;
  logic [P_W-1:0]    p_sum;

  // A stage may advance whenever the stage after it can take its contents,
  // so the pipe sustains one op per cycle and only stalls when both are full.
  always_comb begin
    b_adv    = ~b_vld | out_ready;
    a_adv    = ~a_vld | b_adv;
    in_ready = a_adv;
    accept   = in_valid & a_adv;
  end

  // Partial products, each operand widened to the result width so no
  // product bits are lost.
  always_comb begin
    p_lo  = LO_W'(m_a_frac24) * LO_W'(m_b_frac24[SPLIT-1:0]);
    p_hi  = HI_W'(m_a_frac24) * HI_W'(m_b_frac24[FRAC_W-1:SPLIT]);
    p_sum = (P_W'(a_p_hi) << SPLIT) + P_W'(a_p_lo);
  end

  // Stage A
  always_ff @(posedge clk) begin
    if (rst) begin
      a_vld          <= 1'b0;
      a_sign         <= 1'b0;
      a_exp10        <= '0;
      a_is_inf_nan   <= 1'b0;
      a_inf_nan_frac <= '0;
      a_rm           <= '0;
      a_p_lo         <= '0;
      a_p_hi         <= '0;
    end else begin
      if (flush)
        a_vld <= 1'b0;
      else if (a_adv)
        a_vld <= accept;
      // Data may load during a flush; the cleared valid bit hides it.
      if (accept) begin
        a_sign         <= m_sign;
        a_exp10        <= m_exp10;
        a_is_inf_nan   <= m_is_inf_nan;
        a_inf_nan_frac <= m_inf_nan_frac;
        a_rm           <= m_rm;
        a_p_lo         <= p_lo;
        a_p_hi         <= p_hi;
      end
    end
  end

  // Stage B / outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      b_vld          <= 1'b0;
      n_sign         <= 1'b0;
      n_exp10        <= '0;
      n_is_inf_nan   <= 1'b0;
      n_inf_nan_frac <= '0;
      n_rm           <= '0;
      n_frac48       <= '0;
    end else begin
      if (flush)
        b_vld <= 1'b0;
      else if (b_adv)
        b_vld <= a_vld;
      if (b_adv) begin
        n_sign         <= a_sign;
        n_exp10        <= a_exp10;
        n_is_inf_nan   <= a_is_inf_nan;
        n_inf_nan_frac <= a_inf_nan_frac;
        n_rm           <= a_rm;
        n_frac48       <= p_sum;
      end
    end
  end

  assign out_valid = b_vld;

endmodule

// File: tb/tb_float_mul_pipe_prod.sv
// Directed testbench for float_mul_pipe_prod.
module tb_float_mul_pipe_prod;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        m_sign;
  logic [9:0]  m_exp10;
  logic        m_is_inf_nan;
  logic [22:0] m_inf_nan_frac;
  logic [23:0] m_a_frac24;
  logic [23:0] m_b_frac24;
  logic [1:0]  m_rm;
  logic        out_valid;
  logic        out_ready;
  logic        n_sign;
  logic [9:0]  n_exp10;
  logic        n_is_inf_nan;
  logic [22:0] n_inf_nan_frac;
  logic [1:0]  n_rm;
  logic [47:0] n_frac48;

  int n_checks = 0;
  int n_fails  = 0;

  float_mul_pipe_prod #(.EXP_W(10), .FRAC_W(24), .SPLIT(12)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .m_sign(m_sign), .m_exp10(m_exp10), .m_is_inf_nan(m_is_inf_nan),
    .m_inf_nan_frac(m_inf_nan_frac), .m_a_frac24(m_a_frac24),
    .m_b_frac24(m_b_frac24), .m_rm(m_rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .n_sign(n_sign), .n_exp10(n_exp10), .n_is_inf_nan(n_is_inf_nan),
    .n_inf_nan_frac(n_inf_nan_frac), .n_rm(n_rm), .n_frac48(n_frac48)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [9:0] e, input logic inf,
                       input logic [22:0] inff, input logic [1:0] rm,
                       input logic [23:0] a, input logic [23:0] b);
    in_valid       = 1'b1;
    m_sign         = s;
    m_exp10        = e;
    m_is_inf_nan   = inf;
    m_inf_nan_frac = inff;
    m_rm           = rm;
    m_a_frac24     = a;
    m_b_frac24     = b;
  endtask

  function automatic logic [47:0] prod(input int unsigned i);
    logic [47:0] a, b;
    a = 48'(24'h800000 + 24'(i * 32'h0001_2345));
    b = 48'(24'hFFFFFF - 24'(i * 32'h0000_7777));
    return a * b;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    m_sign = 1'b0; m_exp10 = '0; m_is_inf_nan = 1'b0; m_inf_nan_frac = '0;
    m_rm = '0; m_a_frac24 = '0; m_b_frac24 = '0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_frac", 64'(n_frac48), 64'd0);
    chk("rst_exp", 64'(n_exp10), 64'd0);

    // 1.0 * 1.0, two-cycle latency
    drive(1'b1, 10'h07f, 1'b0, 23'h0, 2'd2, 24'h800000, 24'h800000);
    step();
    in_valid = 1'b0;
    chk("t1_not_yet", 64'(out_valid), 64'd0);
    step();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_frac", 64'(n_frac48), 64'h4000_0000_0000);
    chk("t1_exp", 64'(n_exp10), 64'h07f);
    chk("t1_sign", 64'(n_sign), 64'd1);
    chk("t1_rm", 64'(n_rm), 64'd2);
    step();
    chk("t1_drain", 64'(out_valid), 64'd0);

    // Max fractions, and a*1 with inf/NaN side fields
    drive(1'b0, 10'h3ff, 1'b0, 23'h0, 2'd1, 24'hFFFFFF, 24'hFFFFFF);
    step();
    drive(1'b1, 10'h001, 1'b1, 23'h400000, 2'd3, 24'h000001, 24'hABCDEF);
    step();
    in_valid = 1'b0;
    chk("t2a_valid", 64'(out_valid), 64'd1);
    chk("t2a_frac", 64'(n_frac48), 64'hFFFF_FE00_0001);
    chk("t2a_exp", 64'(n_exp10), 64'h3ff);
    chk("t2a_inf", 64'(n_is_inf_nan), 64'd0);
    step();
    chk("t2b_valid", 64'(out_valid), 64'd1);
    chk("t2b_frac", 64'(n_frac48), 64'h0000_00AB_CDEF);
    chk("t2b_inf", 64'(n_is_inf_nan), 64'd1);
    chk("t2b_inff", 64'(n_inf_nan_frac), 64'h400000);
    chk("t2b_rm", 64'(n_rm), 64'd3);
    step();
    chk("t2_drain", 64'(out_valid), 64'd0);

    // Eight back-to-back ops at full throughput
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 10'(i), 1'b0, 23'h0, 2'd0,
            24'h800000 + 24'(i * 32'h0001_2345),
            24'hFFFFFF - 24'(i * 32'h0000_7777));
      chk("t3_in_ready", 64'(in_ready), 64'd1);
      step();
      if (i >= 1) begin
        chk("t3_valid", 64'(out_valid), 64'd1);
        chk("t3_exp", 64'(n_exp10), 64'(i - 1));
        chk("t3_frac", 64'(n_frac48), 64'(prod(i - 1)));
      end
    end
    in_valid = 1'b0;
    step();
    chk("t3_last_valid", 64'(out_valid), 64'd1);
    chk("t3_last_exp", 64'(n_exp10), 64'd7);
    chk("t3_last_frac", 64'(n_frac48), 64'(prod(7)));
    step();
    chk("t3_drain", 64'(out_valid), 64'd0);

    // Backpressure: three ops offered with out_ready low
    out_ready = 1'b0;
    drive(1'b0, 10'h010, 1'b0, 23'h0, 2'd0, 24'h000002, 24'h000003);  // X = 6
    step();
    drive(1'b0, 10'h011, 1'b0, 23'h0, 2'd0, 24'h000010, 24'h001000);  // Y = 0x10000
    step();
    chk("t4_x_valid", 64'(out_valid), 64'd1);
    chk("t4_x_frac", 64'(n_frac48), 64'h6);
    chk("t4_full_ready", 64'(in_ready), 64'd0);
    drive(1'b0, 10'h012, 1'b0, 23'h0, 2'd0, 24'h800000, 24'h000002);  // Z = 0x1000000
    step();
    chk("t4_hold_frac", 64'(n_frac48), 64'h6);
    chk("t4_hold_exp", 64'(n_exp10), 64'h010);
    chk("t4_hold_ready", 64'(in_ready), 64'd0);
    step();
    chk("t4_hold2_frac", 64'(n_frac48), 64'h6);
    out_ready = 1'b1;
    #1;
    chk("t4_release_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("t4_y_valid", 64'(out_valid), 64'd1);
    chk("t4_y_frac", 64'(n_frac48), 64'h10000);
    chk("t4_y_exp", 64'(n_exp10), 64'h011);
    step();
    chk("t4_z_valid", 64'(out_valid), 64'd1);
    chk("t4_z_frac", 64'(n_frac48), 64'h1000000);
    chk("t4_z_exp", 64'(n_exp10), 64'h012);
    step();
    chk("t4_drain", 64'(out_valid), 64'd0);

    // Flush with two ops in flight and a third offered
    drive(1'b0, 10'h020, 1'b0, 23'h0, 2'd0, 24'h000005, 24'h000005);
    step();
    drive(1'b0, 10'h021, 1'b0, 23'h0, 2'd0, 24'h000007, 24'h000007);
    step();
    drive(1'b0, 10'h022, 1'b0, 23'h0, 2'd0, 24'h000009, 24'h000009);
    flush = 1'b1;
    #1;
    chk("t5_flush_ready", 64'(in_ready), 64'd1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t5_flush_v1", 64'(out_valid), 64'd0);
    step();
    chk("t5_flush_v2", 64'(out_valid), 64'd0);
    step();
    chk("t5_flush_v3", 64'(out_valid), 64'd0);

    // Reset with a full, stalled pipe
    out_ready = 1'b0;
    drive(1'b1, 10'h055, 1'b1, 23'h1, 2'd1, 24'h123456, 24'h654321);
    step();
    drive(1'b1, 10'h056, 1'b1, 23'h2, 2'd2, 24'hABCDEF, 24'hFEDCBA);
    step();
    in_valid = 1'b0;
    chk("t6_pre_valid", 64'(out_valid), 64'd1);
    chk("t6_pre_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_frac", 64'(n_frac48), 64'd0);
    chk("t6_exp", 64'(n_exp10), 64'd0);
    chk("t6_sign", 64'(n_sign), 64'd0);
    chk("t6_ready", 64'(in_ready), 64'd1);
    step();
    chk("t6_no_partial", 64'(out_valid), 64'd0);
    chk("t6_frac_after", 64'(n_frac48), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
